// File: rtl/writeback_queue_if.sv
// Producer (ALU/load) and register-file write bundle for writeback_queue.
// master = producers + register file side, slave = the queue.
interface writeback_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              load_valid;
   logic [ADDR_W-1:0] load_rd;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              register_write_valid;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] reg_write_data;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output load_valid, load_rd, load_data,
      input  alu_ready, load_ready,
      input  register_write_valid, write_reg, reg_write_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  load_valid, load_rd, load_data,
      output alu_ready, load_ready,
      output register_write_valid, write_reg, reg_write_data
   );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback FIFO feeding the register file, with rs1/rs2 hazard flags.
// Optional WB_FORWARD_EN adds youngest-match forwarding data outputs.
module writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   writeback_queue_if.slave       bus,
   input  logic                   wb_stall_i,
   input  logic [ADDR_W-1:0]      query_rs1_i,
   input  logic [ADDR_W-1:0]      query_rs2_i,
   output logic                   pending_rs1_o,
   output logic                   pending_rs2_o,
`ifdef WB_FORWARD_EN
   output logic [DATA_W-1:0]      fwd_data1_o,
   output logic [DATA_W-1:0]      fwd_data2_o,
`endif
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_W-1:0] X31 = ADDR_W'(31);

   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              full;
   logic              load_fire;
   logic              alu_fire;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_data;

   assign full      = count_q == CW'(DEPTH);
   assign load_fire = bus.load_valid && !full;
   assign alu_fire  = bus.alu_valid && !full && !bus.load_valid;
   assign in_rd     = load_fire ? bus.load_rd : bus.alu_rd;
   assign in_data   = load_fire ? bus.load_data : bus.alu_data;
   // x31 is not writable: handshake completes, nothing is queued
   assign push      = (load_fire || alu_fire) && (in_rd != X31);
   assign pop       = !wb_stall_i && (count_q != '0);

   assign bus.load_ready           = !full;
   assign bus.alu_ready            = !full && !bus.load_valid;
   assign bus.register_write_valid = vld_q;
   assign bus.write_reg            = wreg_q;
   assign bus.reg_write_data       = wdata_q;
   assign count_o                  = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = 1'b0;
      wreg_d   = wreg_q;
      wdata_d  = wdata_q;
      if (pop) begin
         vld_d    = 1'b1;
         wreg_d   = rd_q[rd_ptr_q];
         wdata_d  = data_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         vld_q    <= 1'b0;
         wreg_q   <= '0;
         wdata_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         vld_q    <= vld_d;
         wreg_q   <= wreg_d;
         wdata_q  <= wdata_d;
         if (push) begin
            rd_q[wr_ptr_q]   <= in_rd;
            data_q[wr_ptr_q] <= in_data;
         end
      end
   end

   logic [1:0][ADDR_W-1:0] qry;
   logic [1:0]             hit;
`ifdef WB_FORWARD_EN
   logic [1:0][DATA_W-1:0] fwd;
`endif

   assign qry[0] = query_rs1_i;
   assign qry[1] = query_rs2_i;

   // Scan oldest to youngest so the last match is the youngest write
   always_comb begin : hazard_b
      logic [PW-1:0] idx;
      idx = '0;
      hit = '0;
`ifdef WB_FORWARD_EN
      fwd = '0;
`endif
      for (int i = 0; i < 2; i++) begin
         if (vld_q && wreg_q == qry[i]) begin
            hit[i] = 1'b1;
`ifdef WB_FORWARD_EN
            fwd[i] = wdata_q;
`endif
         end
         for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q && rd_q[idx] == qry[i]) begin
               hit[i] = 1'b1;
`ifdef WB_FORWARD_EN
               fwd[i] = data_q[idx];
`endif
            end
         end
         if (qry[i] == X31) begin
            hit[i] = 1'b0;
`ifdef WB_FORWARD_EN
            fwd[i] = '0;
`endif
         end
      end
   end

   assign pending_rs1_o = hit[0];
   assign pending_rs2_o = hit[1];
`ifdef WB_FORWARD_EN
   assign fwd_data1_o   = fwd[0];
   assign fwd_data2_o   = fwd[1];
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_writeback_queue;
   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_stall;
   logic [4:0]  q1, q2;
   logic        pend1, pend2;
   logic [2:0]  cnt;
`ifdef WB_FORWARD_EN
   logic [31:0] fwd1, fwd2;
`endif
   int n_cmp = 0;
   int n_err = 0;

   writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

   writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (wb),
      .wb_stall_i    (wb_stall),
      .query_rs1_i   (q1),
      .query_rs2_i   (q2),
      .pending_rs1_o (pend1),
      .pending_rs2_o (pend2),
`ifdef WB_FORWARD_EN
      .fwd_data1_o   (fwd1),
      .fwd_data2_o   (fwd2),
`endif
      .count_o       (cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        m_q[$];
   bit          m_vld;
   logic [4:0]  m_rd;
   logic [31:0] m_data;

   function automatic bit m_pend(logic [4:0] q);
      if (q == 5'd31) return 1'b0;
      if (m_vld && m_rd == q) return 1'b1;
      foreach (m_q[i]) if (m_q[i].rd == q) return 1'b1;
      return 1'b0;
   endfunction

`ifdef WB_FORWARD_EN
   function automatic logic [31:0] m_fwd(logic [4:0] q);
      logic [31:0] r;
      r = '0;
      if (q == 5'd31) return '0;
      if (m_vld && m_rd == q) r = m_data;
      foreach (m_q[i]) if (m_q[i].rd == q) r = m_q[i].data;
      return r;
   endfunction
`endif

   task automatic m_reset();
      m_q.delete();
      m_vld  = 1'b0;
      m_rd   = '0;
      m_data = '0;
   endtask

   task automatic m_edge(bit fire, ent_t e, bit stall);
      ent_t h;
      if (!stall && m_q.size() > 0) begin
         h      = m_q.pop_front();
         m_vld  = 1'b1;
         m_rd   = h.rd;
         m_data = h.data;
      end else begin
         m_vld = 1'b0;
      end
      if (fire && e.rd != 5'd31) m_q.push_back(e);
   endtask

   function automatic logic [4:0] rnd_rd();
      if ($urandom_range(0, 9) == 0) return 5'd31;
      return 5'($urandom_range(0, 7));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb.alu_valid  = 1'b0;
      wb.alu_rd     = '0;
      wb.alu_data   = '0;
      wb.load_valid = 1'b0;
      wb.load_rd    = '0;
      wb.load_data  = '0;
      wb_stall      = 1'b0;
      q1            = '0;
      q2            = '0;
   endtask

   task automatic test_reset();
      idle();
      #1 reset = 1'b0;
      #1;
      n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL rst0_count got %0d want 0", cnt); end
      n_cmp++; if (wb.register_write_valid !== 1'b0) begin n_err++; $display("FAIL rst0_rwv got %b want 0", wb.register_write_valid); end
      n_cmp++; if (wb.alu_ready !== 1'b1 || wb.load_ready !== 1'b1) begin n_err++; $display("FAIL rst0_ready got %b%b want 11", wb.alu_ready, wb.load_ready); end
      tick();
      reset = 1'b1;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h77;
      tick();
      idle();
      tick();
      tick();
      n_cmp++; if (wb.write_reg !== 5'd9) begin n_err++; $display("FAIL pre_rst_wreg got %0d want 9", wb.write_reg); end
      wb_stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         wb.alu_valid = 1'b1; wb.alu_rd = 5'(i); wb.alu_data = 32'(i);
         tick();
      end
      wb.alu_valid = 1'b0;
      #1;
      n_cmp++; if (cnt !== 3'd3) begin n_err++; $display("FAIL pre_rst_count got %0d want 3", cnt); end
      reset = 1'b0;
      #1;
      n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL async_count got %0d want 0", cnt); end
      n_cmp++; if (wb.register_write_valid !== 1'b0) begin n_err++; $display("FAIL async_rwv got %b want 0", wb.register_write_valid); end
      n_cmp++; if (wb.write_reg !== 5'd0 || wb.reg_write_data !== 32'd0) begin n_err++; $display("FAIL async_wreg got %0d/%h want 0/0", wb.write_reg, wb.reg_write_data); end
      n_cmp++; if (wb.alu_ready !== 1'b1 || wb.load_ready !== 1'b1) begin n_err++; $display("FAIL async_ready got %b%b want 11", wb.alu_ready, wb.load_ready); end
      tick();
      reset = 1'b1;
      idle();
   endtask

   task automatic test_latency();
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd10; wb.alu_data = 32'h20;
      #1;
      n_cmp++; if (wb.alu_ready !== 1'b1) begin n_err++; $display("FAIL lat_ready got %b want 1", wb.alu_ready); end
      tick();
      wb.alu_valid = 1'b0;
      n_cmp++; if (wb.register_write_valid !== 1'b0 || cnt !== 3'd1) begin n_err++; $display("FAIL lat_n1 got rwv=%b cnt=%0d want 0/1", wb.register_write_valid, cnt); end
      tick();
      n_cmp++; if (wb.register_write_valid !== 1'b1 || wb.write_reg !== 5'd10 || wb.reg_write_data !== 32'h20) begin n_err++; $display("FAIL lat_n2 got %b/%0d/%h want 1/10/20", wb.register_write_valid, wb.write_reg, wb.reg_write_data); end
      tick();
      n_cmp++; if (wb.register_write_valid !== 1'b0 || wb.write_reg !== 5'd10) begin n_err++; $display("FAIL lat_n3 got %b/%0d want 0/10", wb.register_write_valid, wb.write_reg); end
   endtask

   task automatic test_priority();
      wb.load_valid = 1'b1; wb.load_rd = 5'd5; wb.load_data = 32'h55;
      wb.alu_valid  = 1'b1; wb.alu_rd  = 5'd6; wb.alu_data  = 32'h66;
      #1;
      n_cmp++; if (wb.load_ready !== 1'b1 || wb.alu_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready got l=%b a=%b want 1/0", wb.load_ready, wb.alu_ready); end
      tick();
      wb.load_valid = 1'b0;
      #1;
      n_cmp++; if (wb.alu_ready !== 1'b1 || cnt !== 3'd1) begin n_err++; $display("FAIL prio_alu got a=%b cnt=%0d want 1/1", wb.alu_ready, cnt); end
      tick();
      wb.alu_valid = 1'b0;
      n_cmp++; if (wb.register_write_valid !== 1'b1 || wb.write_reg !== 5'd5 || wb.reg_write_data !== 32'h55) begin n_err++; $display("FAIL prio_w1 got %b/%0d/%h want 1/5/55", wb.register_write_valid, wb.write_reg, wb.reg_write_data); end
      tick();
      n_cmp++; if (wb.register_write_valid !== 1'b1 || wb.write_reg !== 5'd6 || wb.reg_write_data !== 32'h66) begin n_err++; $display("FAIL prio_w2 got %b/%0d/%h want 1/6/66", wb.register_write_valid, wb.write_reg, wb.reg_write_data); end
      tick();
      n_cmp++; if (wb.register_write_valid !== 1'b0 || cnt !== 3'd0) begin n_err++; $display("FAIL prio_end got %b/%0d want 0/0", wb.register_write_valid, cnt); end
   endtask

   task automatic test_full_stall();
      wb_stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wb.alu_valid = 1'b1; wb.alu_rd = 5'(i); wb.alu_data = 32'h100 + 32'(i);
         tick();
      end
      wb.alu_rd = 5'd20; wb.load_valid = 1'b1; wb.load_rd = 5'd21;
      #1;
      n_cmp++; if (cnt !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", cnt); end
      n_cmp++; if (wb.alu_ready !== 1'b0 || wb.load_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b%b want 00", wb.alu_ready, wb.load_ready); end
      n_cmp++; if (wb.register_write_valid !== 1'b0) begin n_err++; $display("FAIL full_rwv got %b want 0", wb.register_write_valid); end
      wb_stall = 1'b0;
      #1;
      n_cmp++; if (wb.load_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_ready got %b want 0", wb.load_ready); end
      wb.alu_valid = 1'b0; wb.load_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_cmp++; if (wb.register_write_valid !== 1'b1 || wb.write_reg !== 5'(i) || wb.reg_write_data !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL drain%0d got %b/%0d/%h want 1/%0d/%h", i, wb.register_write_valid, wb.write_reg, wb.reg_write_data, i, 32'h100 + 32'(i)); end
      end
      n_cmp++; if (cnt !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", cnt); end
      tick();
      idle();
   endtask

   task automatic test_rd31();
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd31; wb.alu_data = 32'h99; q1 = 5'd31;
      #1;
      n_cmp++; if (wb.alu_ready !== 1'b1) begin n_err++; $display("FAIL r31_ready got %b want 1", wb.alu_ready); end
      tick();
      wb.alu_valid = 1'b0;
      n_cmp++; if (cnt !== 3'd0 || pend1 !== 1'b0) begin n_err++; $display("FAIL r31_cnt got cnt=%0d pend=%b want 0/0", cnt, pend1); end
      tick();
      n_cmp++; if (wb.register_write_valid !== 1'b0) begin n_err++; $display("FAIL r31_rwv got %b want 0", wb.register_write_valid); end
      idle();
   endtask

   task automatic test_same_rd();
      wb_stall = 1'b1;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h1;
      tick();
      wb.alu_data = 32'h2;
      tick();
      wb.alu_valid = 1'b0; q1 = 5'd7; q2 = 5'd8;
      #1;
      n_cmp++; if (pend1 !== 1'b1 || pend2 !== 1'b0 || cnt !== 3'd2) begin n_err++; $display("FAIL same_pend got %b%b cnt=%0d want 10/2", pend1, pend2, cnt); end
`ifdef WB_FORWARD_EN
      n_cmp++; if (fwd1 !== 32'h2 || fwd2 !== 32'h0) begin n_err++; $display("FAIL same_fwd got %h/%h want 2/0", fwd1, fwd2); end
`endif
      wb_stall = 1'b0;
      tick();
      n_cmp++; if (pend1 !== 1'b1 || wb.reg_write_data !== 32'h1) begin n_err++; $display("FAIL same_w1 got pend=%b d=%h want 1/1", pend1, wb.reg_write_data); end
`ifdef WB_FORWARD_EN
      n_cmp++; if (fwd1 !== 32'h2) begin n_err++; $display("FAIL same_fwd_w1 got %h want 2", fwd1); end
`endif
      tick();
      n_cmp++; if (pend1 !== 1'b1 || wb.reg_write_data !== 32'h2) begin n_err++; $display("FAIL same_w2 got pend=%b d=%h want 1/2", pend1, wb.reg_write_data); end
      tick();
      n_cmp++; if (pend1 !== 1'b0) begin n_err++; $display("FAIL same_clear got %b want 0", pend1); end
      idle();
   endtask

   task automatic test_random();
      bit          av, lv, stall, full, lr, ar, lf, af;
      logic [4:0]  ard, lrd;
      logic [31:0] adat, ldat;
      ent_t        e;
      av = 0; lv = 0; ard = '0; lrd = '0; adat = '0; ldat = '0;
      idle();
      reset = 1'b0;
      #1;
      m_reset();
      tick();
      reset = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (!av && $urandom_range(0, 1) == 1) begin
            av = 1; ard = rnd_rd(); adat = $urandom;
         end
         if (!lv && $urandom_range(0, 2) == 0) begin
            lv = 1; lrd = rnd_rd(); ldat = $urandom;
         end
         stall = ($urandom_range(0, 3) == 0);
         wb.alu_valid = av; wb.alu_rd = ard; wb.alu_data = adat;
         wb.load_valid = lv; wb.load_rd = lrd; wb.load_data = ldat;
         wb_stall = stall;
         q1 = rnd_rd(); q2 = rnd_rd();
         #1;
         full = (m_q.size() == DEPTH);
         lr = !full;
         ar = !full && !lv;
         n_cmp++; if (cnt !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, cnt, m_q.size()); end
         n_cmp++; if (wb.load_ready !== lr || wb.alu_ready !== ar) begin n_err++; $display("FAIL rnd_ready c=%0d got %b%b want %b%b", c, wb.load_ready, wb.alu_ready, lr, ar); end
         n_cmp++; if (wb.register_write_valid !== m_vld || wb.write_reg !== m_rd || wb.reg_write_data !== m_data) begin n_err++; $display("FAIL rnd_write c=%0d got %b/%0d/%h want %b/%0d/%h", c, wb.register_write_valid, wb.write_reg, wb.reg_write_data, m_vld, m_rd, m_data); end
         n_cmp++; if (pend1 !== m_pend(q1) || pend2 !== m_pend(q2)) begin n_err++; $display("FAIL rnd_pend c=%0d got %b%b want %b%b", c, pend1, pend2, m_pend(q1), m_pend(q2)); end
`ifdef WB_FORWARD_EN
         n_cmp++; if (fwd1 !== m_fwd(q1) || fwd2 !== m_fwd(q2)) begin n_err++; $display("FAIL rnd_fwd c=%0d got %h/%h want %h/%h", c, fwd1, fwd2, m_fwd(q1), m_fwd(q2)); end
`endif
         lf = lv && lr;
         af = av && ar;
         e.rd   = lf ? lrd : ard;
         e.data = lf ? ldat : adat;
         m_edge(lf || af, e, stall);
         if (lf) lv = 0;
         if (af) av = 0;
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_priority();
      test_full_stall();
      test_rd31();
      test_same_rd();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback stage directly upstream of the register file write port.
- Accepts results from the ALU and the load unit through valid/ready handshakes.
- Buffers results in an in-order FIFO and drains one per cycle onto register_write_valid / write_reg / reg_write_data.
- Gives decode pending-write (hazard) flags for rs1/rs2 so it can stall until the register file holds the value.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
DATA_W, 32, result width
ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
alu_valid  in  1  ALU result valid
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
load_valid  in  1  load result valid
load_rd  in  ADDR_W  load destination register
load_data  in  DATA_W  load result
load_ready  out  1  load result accepted this cycle when load_valid=1
wb_stall  in  1  hold the queue; no write issued
query_rs1  in  ADDR_W  decode rs1
query_rs2  in  ADDR_W  decode rs2
pending_rs1  out  1  a write to query_rs1 is still outstanding
pending_rs2  out  1  a write to query_rs2 is still outstanding
register_write_valid  out  1  register file write enable
write_reg  out  ADDR_W  register file destination
reg_write_data  out  DATA_W  register file write data
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; pointers = 0; count = 0.
  - register_write_valid, write_reg and reg_write_data all 0.
  - Takes effect mid-operation: buffered results are discarded and in-flight handshakes are lost.
- Ready (combinational from state and load_valid only):
  - load_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH) && !load_valid. Load has fixed priority.
  - Producers must not make valid depend on ready.
  - Valid/data hold until accepted.
- Fire = valid && ready; at most one fire per cycle.
  - Fire with rd = 31 completes the handshake but is not enqueued, because x31 is not writable in the register file.
- Push: at the clock edge, the firing {rd, data} is written at the tail and count increments.
- Full:
  - With count = DEPTH both readies are 0, even if a pop happens in the same cycle.
  - No same-cycle refill when full.
- Drain, evaluated at each edge:
  - wb_stall=1: register_write_valid <= 0; FIFO holds.
  - wb_stall=0 and count>0: head loads the output registers, register_write_valid <= 1, head pops.
  - Otherwise: register_write_valid <= 0.
  - write_reg and reg_write_data keep their last values when not valid.
- Push and pop in the same cycle: count is unchanged.
- Latency: a result accepted in cycle N with an empty FIFO appears as register_write_valid=1 in cycle N+2, for exactly one cycle.
- Order: writes issue strictly in acceptance order, so a later write to the same rd lands last.
- Pointers wrap modulo DEPTH.
- Hazard flags (combinational):
  - pending_rsX = 1 if query_rsX matches rd of any occupied FIFO entry, or matches write_reg while register_write_valid=1.
  - A handshake firing in the current cycle is not included.
  - query = 31 never flags.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - Adds outputs fwd_data1 / fwd_data2 (DATA_W).
  - Each carries the data of the youngest matching pending write (FIFO tail-most match, else the output register); 0 when there is no match.
  - Lets decode bypass instead of stall.
- Not defined: ports absent; only the pending flags exist.

Test Plan:
- Reset low mid-stream with count=3 -> count=0, register_write_valid=0, write_reg=0, both readies 1 immediately, before the next clock edge.
- alu_valid, rd=10, data=0x20 accepted cycle N, empty FIFO -> register_write_valid=1, write_reg=10, reg_write_data=0x20 in cycle N+2 only.
- load (rd=5, 0x55) and alu (rd=6, 0x66) valid together -> load accepted, alu_ready=0; next cycle alu accepted; writes appear rd5 then rd6 on consecutive cycles.
- wb_stall=1 while 4 results (rd 1..4) are pushed -> count=4, readies 0, no writes; release stall -> 4 consecutive writes in order, count returns to 0.
- alu rd=31 data=0x99 -> alu_ready=1 and fire, count stays 0, no register write; query_rs1=31 -> pending_rs1=0.
- Pushes to rd=7 (0x1) then rd=7 (0x2), stall held, query_rs1=7 -> pending_rs1=1; with WB_FORWARD_EN, fwd_data1=0x2.
